cnn_input_loader: RTL and testbench

CNN_INPUT_LOADER -- requirements
Module: cnn_input_loader

---
 rtl/cnn_input_loader.sv | 197 +++++++++++++++++++
 tb/tb_cnn_input_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_input_loader.sv
// -----------------------------------------------------------------------------
// cnn_input_loader
//
// Collects a stream of image elements into one packed frame image and hands
// it to a convolution engine. The frame geometry (height, width, channels) is
// latched on start; elements then arrive col-fastest, then row, then channel,
// and each is placed at its fixed slot in the max-size packed layout, so the
// convolution sees the same addressing whatever the configured geometry is.
// Unused slots stay zero. After the final element the loader pulses
// frame_valid for one cycle and holds the image until the convolution
// reports completion through frame_done.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           begin loading a frame (honoured only when idle)
//   cfg_img_height  frame rows,     legal 1..MAX_IMG_HEIGHT
//   cfg_img_width   frame columns,  legal 1..MAX_IMG_WIDTH
//   cfg_in_channels frame channels, legal 1..MAX_IN_CHANNELS
//   s_valid         stream beat valid
//   s_data          stream element
//   s_last          marks the final element of a frame
//   s_ready         loader accepts a beat (high only while loading)
//   frame_valid     one-cycle pulse, frame_data is complete
//   frame_data      packed image, element idx at [idx*ELEM_WIDTH +: ELEM_WIDTH]
//                   with idx = ch*H_MAX*W_MAX + row*W_MAX + col
//   frame_done      convolution finished with the current frame
//   busy            loader is not idle
//   err             one-cycle pulse: illegal config or s_last misplaced
// -----------------------------------------------------------------------------
module cnn_input_loader #(
    parameter int ELEM_WIDTH      = 8,
    parameter int MAX_IMG_HEIGHT  = 32,
    parameter int MAX_IMG_WIDTH   = 32,
    parameter int MAX_IN_CHANNELS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                cfg_img_height,
    input  logic [7:0]                cfg_img_width,
    input  logic [7:0]                cfg_in_channels,
    input  logic                      s_valid,
    input  logic [ELEM_WIDTH-1:0]     s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic                      frame_valid,
    output logic [MAX_IN_CHANNELS*MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] frame_data,
    input  logic                      frame_done,
    output logic                      busy,
    output logic                      err
);

    localparam int FRAME_W   = MAX_IN_CHANNELS * MAX_IMG_HEIGHT * MAX_IMG_WIDTH * ELEM_WIDTH;
    localparam int PLANE     = MAX_IMG_HEIGHT * MAX_IMG_WIDTH;
    localparam int BIT_IDX_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        EMIT      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0] cfg_h_q, cfg_w_q, cfg_c_q;
    logic [7:0] ch_q, row_q, col_q;

    logic                 cfg_legal;
    logic                 beat_acc;
    logic                 last_pos;
    logic                 col_wrap;
    logic                 row_wrap;
    int                   elem_idx;
    logic [BIT_IDX_W-1:0] bit_base;

    assign cfg_legal = (cfg_img_height  != 8'd0) && (int'(cfg_img_height)  <= MAX_IMG_HEIGHT) &&
                       (cfg_img_width   != 8'd0) && (int'(cfg_img_width)   <= MAX_IMG_WIDTH)  &&
                       (cfg_in_channels != 8'd0) && (int'(cfg_in_channels) <= MAX_IN_CHANNELS);

    assign beat_acc = s_valid && s_ready;
    assign col_wrap = (col_q == cfg_w_q - 8'd1);
    assign row_wrap = (row_q == cfg_h_q - 8'd1);
    assign last_pos = col_wrap && row_wrap && (ch_q == cfg_c_q - 8'd1);

    // Slot address uses the max geometry, not the configured one, so the
    // consumer's layout never depends on the frame size.
    always_comb begin
        elem_idx = int'(ch_q) * PLANE + int'(row_q) * MAX_IMG_WIDTH + int'(col_q);
        bit_base = BIT_IDX_W'(elem_idx * ELEM_WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_ready     = 1'b0;
        frame_valid = 1'b0;
        busy        = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start && cfg_legal) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (beat_acc) begin
                    if (last_pos) begin
                        state_d = EMIT;
                    end else if (s_last) begin
                        // Frame ended early: abandon it without emitting.
                        state_d = IDLE;
                    end
                end
            end
            EMIT: begin
                frame_valid = 1'b1;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Configuration, position counters, frame image and the error pulse.
    // err is registered so a bad final beat flags in the same cycle as
    // frame_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_h_q    <= 8'd0;
            cfg_w_q    <= 8'd0;
            cfg_c_q    <= 8'd0;
            ch_q       <= 8'd0;
            row_q      <= 8'd0;
            col_q      <= 8'd0;
            frame_data <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            cfg_h_q    <= cfg_img_height;
                            cfg_w_q    <= cfg_img_width;
                            cfg_c_q    <= cfg_in_channels;
                            ch_q       <= 8'd0;
                            row_q      <= 8'd0;
                            col_q      <= 8'd0;
                            frame_data <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat_acc) begin
                        frame_data[bit_base +: ELEM_WIDTH] <= s_data;
                        if (last_pos) begin
                            err <= ~s_last;
                        end else if (s_last) begin
                            err <= 1'b1;
                        end else if (col_wrap) begin
                            col_q <= 8'd0;
                            if (row_wrap) begin
                                row_q <= 8'd0;
                                ch_q  <= ch_q + 8'd1;
                            end else begin
                                row_q <= row_q + 8'd1;
                            end
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_input_loader.sv
// -----------------------------------------------------------------------------
// tb_cnn_input_loader
//
// Directed bench for cnn_input_loader: a per-cycle vector table covering the
// basic 2x2x1 frame, illegal configurations, early s_last, late s_last and
// start/frame_done collision, followed by hand-written sequences for reset
// mid-load and a 1x3x3 frame with a gapped valid.
// -----------------------------------------------------------------------------
module tb_cnn_input_loader;

    localparam int EW = 8;
    localparam int MH = 32;
    localparam int MW = 32;
    localparam int MC = 3;
    localparam int FW = MC * MH * MW * EW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    cfg_img_height;
    logic [7:0]    cfg_img_width;
    logic [7:0]    cfg_in_channels;
    logic          s_valid;
    logic [EW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          frame_valid;
    logic [FW-1:0] frame_data;
    logic          frame_done;
    logic          busy;
    logic          err;

    cnn_input_loader #(
        .ELEM_WIDTH      (EW),
        .MAX_IMG_HEIGHT  (MH),
        .MAX_IMG_WIDTH   (MW),
        .MAX_IN_CHANNELS (MC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_img_height  (cfg_img_height),
        .cfg_img_width   (cfg_img_width),
        .cfg_in_channels (cfg_in_channels),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_last          (s_last),
        .s_ready         (s_ready),
        .frame_valid     (frame_valid),
        .frame_data      (frame_data),
        .frame_done      (frame_done),
        .busy            (busy),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    typedef struct {
        logic       start;
        logic [7:0] h;
        logic [7:0] w;
        logic [7:0] c;
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       fd;
        logic       e_rdy;
        logic       e_fv;
        logic       e_busy;
        logic       e_err;
        int         fsel;   // 0 none, 1 frm_a, 2 frm_b, 3 zero, 4 frm_c
    } vec_t;

    vec_t tbl[$];

    logic [FW-1:0] frm_a, frm_b, frm_c, frm_d, frm_z;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic vec_t mk(input int st, input int h, input int w, input int c,
                                input int sv, input int sd, input int sl, input int fd,
                                input int rdy, input int fv, input int bz, input int er,
                                input int fs);
        vec_t v;
        v.start  = st[0];
        v.h      = h[7:0];
        v.w      = w[7:0];
        v.c      = c[7:0];
        v.sv     = sv[0];
        v.sd     = sd[7:0];
        v.sl     = sl[0];
        v.fd     = fd[0];
        v.e_rdy  = rdy[0];
        v.e_fv   = fv[0];
        v.e_busy = bz[0];
        v.e_err  = er[0];
        v.fsel   = fs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [FW-1:0] exp);
        int bad;
        n_vec++;
        if (frame_data !== exp) begin
            n_fail++;
            bad = 0;
            for (int b = FW / EW - 1; b >= 0; b--) begin
                if (frame_data[b*EW +: EW] !== exp[b*EW +: EW]) bad = b;
            end
            $display("FAIL %s: byte %0d got %0h, want %0h", name, bad,
                     frame_data[bad*EW +: EW], exp[bad*EW +: EW]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fv_cnt;
        int busy_seen;
        logic fv_at_last;

        rst_n           = 1'b0;
        start           = 1'b0;
        cfg_img_height  = 8'd0;
        cfg_img_width   = 8'd0;
        cfg_in_channels = 8'd0;
        s_valid         = 1'b0;
        s_data          = '0;
        s_last          = 1'b0;
        frame_done      = 1'b0;

        frm_z = '0;
        frm_a = '0;
        frm_a[0*EW +: EW]  = 8'd1;
        frm_a[1*EW +: EW]  = 8'd2;
        frm_a[32*EW +: EW] = 8'd3;
        frm_a[33*EW +: EW] = 8'd4;
        frm_b = '0;
        frm_b[0*EW +: EW] = 8'd5;
        frm_b[1*EW +: EW] = 8'd6;
        frm_c = '0;
        frm_c[0*EW +: EW] = 8'd7;
        frm_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int col = 0; col < 3; col++) begin
                frm_d[(ch*1024 + col)*EW +: EW] = 8'(ch*3 + col + 1);
            end
        end

        // 2x2x1 frame, s_last on beat 4
        tbl.push_back(mk(1,2,2,1, 0,0,0,0, 1,0,1,0, 3));
        tbl.push_back(mk(0,0,0,0, 1,1,0,0, 1,0,1,0, 0));
        tbl.push_back(mk(0,0,0,0, 1,2,0,0, 1,0,1,0, 0));
        tbl.push_back(mk(0,0,0,0, 1,3,0,0, 1,0,1,0, 0));
        tbl.push_back(mk(0,0,0,0, 1,4,1,0, 0,1,1,0, 1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,0, 1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 1));
        // idle: beats and frame_done have no effect
        tbl.push_back(mk(0,0,0,0, 1,170,1,1, 0,0,0,0, 1));
        // illegal configurations: channels 4, height 0, width 33
        tbl.push_back(mk(1,2,2,4, 0,0,0,0, 0,0,0,1, 1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1));
        tbl.push_back(mk(1,0,2,1, 0,0,0,0, 0,0,0,1, 1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1));
        tbl.push_back(mk(1,2,33,1, 0,0,0,0, 0,0,0,1, 1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1));
        // 2x2x1 frame with s_last on beat 2
        tbl.push_back(mk(1,2,2,1, 0,0,0,0, 1,0,1,0, 3));
        tbl.push_back(mk(0,0,0,0, 1,5,0,0, 1,0,1,0, 0));
        tbl.push_back(mk(0,0,0,0, 1,6,1,0, 0,0,0,1, 2));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 2));
        // 1x1x1 frame, final beat without s_last, then start/done collision
        tbl.push_back(mk(1,1,1,1, 0,0,0,0, 1,0,1,0, 3));
        tbl.push_back(mk(0,0,0,0, 1,7,0,0, 0,1,1,1, 4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,0, 4));
        tbl.push_back(mk(1,2,2,1, 0,0,0,0, 0,0,1,0, 4));
        tbl.push_back(mk(1,2,2,1, 0,0,0,1, 0,0,0,0, 4));
        tbl.push_back(mk(1,2,2,1, 0,0,0,0, 1,0,1,0, 3));

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset s_ready", 32'(s_ready), 32'd0);
        chk("reset frame_valid", 32'(frame_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk_frame("reset frame_data", frm_z);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            start           = tbl[i].start;
            cfg_img_height  = tbl[i].h;
            cfg_img_width   = tbl[i].w;
            cfg_in_channels = tbl[i].c;
            s_valid         = tbl[i].sv;
            s_data          = tbl[i].sd;
            s_last          = tbl[i].sl;
            frame_done      = tbl[i].fd;
            tick();
            chk($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d frame_valid", i), 32'(frame_valid), 32'(tbl[i].e_fv));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].e_err));
            case (tbl[i].fsel)
                1: chk_frame($sformatf("vec%0d frame_data", i), frm_a);
                2: chk_frame($sformatf("vec%0d frame_data", i), frm_b);
                3: chk_frame($sformatf("vec%0d frame_data", i), frm_z);
                4: chk_frame($sformatf("vec%0d frame_data", i), frm_c);
                default: begin
                end
            endcase
        end

        // reset after 3 of 4 beats of a 2x2x1 frame (table left it loading)
        start      = 1'b0;
        frame_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            s_valid = 1'b1;
            s_data  = 8'(k);
            s_last  = 1'b0;
            tick();
        end
        chk("midload s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("abort s_ready", 32'(s_ready), 32'd0);
        chk("abort frame_valid", 32'(frame_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort err", 32'(err), 32'd0);
        chk_frame("abort frame_data", frm_z);
        tick();
        rst_n     = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'd4;
        s_last    = 1'b1;
        fv_cnt    = 0;
        busy_seen = 0;
        repeat (6) begin
            tick();
            fv_cnt    += int'(frame_valid);
            busy_seen += int'(busy);
        end
        chk("post-reset frame_valid count", 32'(fv_cnt), 32'd0);
        chk("post-reset busy count", 32'(busy_seen), 32'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;

        // 1x3x3 frame with s_valid toggling every other cycle
        start           = 1'b1;
        cfg_img_height  = 8'd1;
        cfg_img_width   = 8'd3;
        cfg_in_channels = 8'd3;
        tick();
        start = 1'b0;
        chk("gap start busy", 32'(busy), 32'd1);
        fv_cnt     = 0;
        fv_at_last = 1'b0;
        for (int k = 0; k < 9; k++) begin
            s_valid = 1'b0;
            tick();
            fv_cnt += int'(frame_valid);
            s_valid = 1'b1;
            s_data  = 8'(k + 1);
            s_last  = (k == 8);
            tick();
            fv_cnt += int'(frame_valid);
            if (k == 8) fv_at_last = frame_valid;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (4) begin
            tick();
            fv_cnt += int'(frame_valid);
        end
        chk("gap frame_valid after last beat", 32'(fv_at_last), 32'd1);
        chk("gap frame_valid count", 32'(fv_cnt), 32'd1);
        chk("gap ch1 col0 byte 1024", 32'(frame_data[1024*EW +: EW]), 32'd4);
        chk_frame("gap frame_data", frm_d);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("gap done busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
